// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder.
// master = producer/consumer side, slave = encoder side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3,
    output in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr,
    input  out_last, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3,
    input  in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr,
    output out_last, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with LI pseudo expansion and a one-word output register.
// Optional ENCODER_CHECK_EN flags malformed immediates on out_err.
module instr_encoder #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic         clk,
  input logic         reset,
  instr_encoder_if.slave bus
);
  typedef enum logic {IDLE, EMIT_LO} state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic [31:0] lo_q, lo_d;

  logic        accept, out_fire;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [31:0] enc_c, lo_c;
  logic        two_c;
  logic        fits12;
  logic [19:0] hi_c;

  assign imm      = bus.in_imm;
  assign rd       = bus.in_rd;
  assign fits12   = (&imm[31:11]) | ~(|imm[31:11]);
  // Upper part is rounded so that the sign-extended addi lands exactly.
  assign hi_c     = imm[31:12] + {19'd0, imm[11]};
  assign out_fire = out_valid_q & bus.out_ready;

  assign bus.in_ready  = (state_q == IDLE) &
                         (~out_valid_q | bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_last  = out_last_q;

  always_comb begin
    enc_c = NOP_INSTR;
    lo_c  = NOP_INSTR;
    two_c = 1'b0;
    unique case (bus.in_fmt)
      3'd0: enc_c = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                     bus.in_funct3, rd, bus.in_opcode};
      3'd1: enc_c = {imm[11:0], bus.in_rs1, bus.in_funct3,
                     rd, bus.in_opcode};
      3'd2: enc_c = {imm[11:5], bus.in_rs2, bus.in_rs1,
                     bus.in_funct3, imm[4:0], bus.in_opcode};
      3'd3: enc_c = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1,
                     bus.in_funct3, imm[4:1], imm[11],
                     bus.in_opcode};
      3'd4: enc_c = {imm[31:12], rd, bus.in_opcode};
      3'd5: enc_c = {imm[20], imm[10:1], imm[11], imm[19:12],
                     rd, bus.in_opcode};
      3'd6: begin
        if (fits12) begin
          enc_c = {imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else if (imm[11:0] == 12'd0) begin
          enc_c = {imm[31:12], rd, 7'h37};
        end else begin
          enc_c = {hi_c, rd, 7'h37};
          lo_c  = {imm[11:0], rd, 3'b000, rd, 7'h13};
          two_c = 1'b1;
        end
      end
      3'd7: enc_c = NOP_INSTR;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q & ~out_fire;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    lo_d        = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_c;
          out_last_d  = ~two_c;
          if (two_c) begin
            lo_d    = lo_c;
            state_d = EMIT_LO;
          end
        end
      end
      EMIT_LO: begin
        if (out_fire) begin
          out_valid_d = 1'b1;
          out_instr_d = lo_q;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_last_q  <= 1'b0;
      lo_q        <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      lo_q        <= lo_d;
    end
  end

`ifdef ENCODER_CHECK_EN
  logic err_c;
  logic out_err_q, out_err_d;

  always_comb begin
    err_c = 1'b0;
    unique case (bus.in_fmt)
      3'd1, 3'd2: err_c = ~fits12;
      3'd3: err_c = imm[0] |
                    ~((&imm[31:12]) | ~(|imm[31:12]));
      3'd5: err_c = imm[0] |
                    ~((&imm[31:20]) | ~(|imm[31:20]));
      3'd7: err_c = 1'b1;
      default: err_c = 1'b0;
    endcase
  end

  // The addi half of LI keeps the flag of its lui half.
  always_comb begin
    out_err_d = out_err_q;
    if (state_q == IDLE && accept) out_err_d = err_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_err_q <= 1'b0;
    else       out_err_q <= out_err_d;
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule
